// File: rtl/sdram_ctrl_pkg.sv
// sdram_ctrl_pkg: shared constants for the SDRAM command controller.
//   - command codes accepted on the command port
//   - FSM state encodings exposed on the state port
//   - default cycle counts for the reset sequences and the watchdog
package sdram_ctrl_pkg;

  localparam logic [3:0] CMD_RUN         = 4'd1;
  localparam logic [3:0] CMD_LOAD        = 4'd2;
  localparam logic [3:0] CMD_RESET_FIFO  = 4'd3;
  localparam logic [3:0] CMD_RESET_SDRAM = 4'd4;
  localparam logic [3:0] CMD_RETURN      = 4'd6;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_RESET_SDRAM = 3'd1;
  localparam logic [2:0] ST_RESET_FIFO  = 3'd2;
  localparam logic [2:0] ST_LOAD        = 3'd3;
  localparam logic [2:0] ST_READ        = 3'd4;

  localparam int DEF_RST_SDRAM_CYC = 10000;
  localparam int DEF_RST_FIFO_CYC  = 128;
  localparam int DEF_WDOG_CYC      = 65535;

  // True for the two page-transfer states.
  function automatic logic is_burst(input logic [2:0] st);
    return (st == ST_LOAD) || (st == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_rst_timer.sv
// sdram_rst_timer: reset-duration down-counter shared by both reset sequences.
// Ports:
//   clk_i, rst_n_i    : clock, async active-low reset
//   load_i            : start a new duration (load_val_i = cycles - 1)
//   load_val_i        : terminal-count preload
//   done_o            : high on the last cycle of the duration
module sdram_rst_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  assign done_o = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = load_val_i;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/sdram_cmd_ctrl.sv
// sdram_cmd_ctrl: command sequencer for an SDRAM page engine.
// Accepts commands in IDLE, runs SDRAM/FIFO reset sequences and page
// write/read bursts with an optional page target.
// Optional feature: define SDRAM_CTRL_WDOG_EN to add a burst watchdog that
// aborts a stalled LOAD/READ after WDOG_CYC cycles and flags err_timeout.
// Ports: sdramclk / sdram_rst_n (clock, async active-low reset);
//   command, cmd_valid, cmd_ready (handshake); burst_pages, fifo_mask,
//   page_done (inputs); cmd_pagewrite, cmd_pageread, state, fifo_rst,
//   sdramctrl_reset, busy, pages_cnt, err_timeout (outputs).
//
// state          | meaning
// IDLE           | waiting for a command
// RESET_SDRAM    | sdramctrl_reset held for RST_SDRAM_CYC cycles
// RESET_FIFO     | fifo_rst held at the latched mask for RST_FIFO_CYC cycles
// LOAD           | page write burst, counting page_done
// READ           | page read burst, counting page_done
module sdram_cmd_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int NUM_FIFO      = 2,
  parameter int CNT_W         = 16,
  parameter int RST_SDRAM_CYC = DEF_RST_SDRAM_CYC,
  parameter int RST_FIFO_CYC  = DEF_RST_FIFO_CYC,
  parameter int PAGE_W        = 16,
  parameter int WDOG_CYC      = DEF_WDOG_CYC
) (
  input  logic                sdramclk,
  input  logic                sdram_rst_n,
  input  logic [3:0]          command,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PAGE_W-1:0]   burst_pages,
  input  logic [NUM_FIFO-1:0] fifo_mask,
  input  logic                page_done,
  output logic                cmd_pagewrite,
  output logic                cmd_pageread,
  output logic [2:0]          state,
  output logic [NUM_FIFO-1:0] fifo_rst,
  output logic                sdramctrl_reset,
  output logic                busy,
  output logic [PAGE_W-1:0]   pages_cnt,
  output logic                err_timeout
);

  // Timer preloads are duration-1: done_o fires on the last held cycle.
  localparam logic [CNT_W-1:0] SDRAM_LOAD = CNT_W'(RST_SDRAM_CYC - 1);
  localparam logic [CNT_W-1:0] FIFO_LOAD  = CNT_W'(RST_FIFO_CYC - 1);

  logic [2:0]          state_q, state_d;
  logic [PAGE_W-1:0]   pages_q, pages_d;
  logic [PAGE_W-1:0]   target_q, target_d;
  logic [NUM_FIFO-1:0] fifo_rst_q, fifo_rst_d;
  logic                sdrst_q, sdrst_d;
  logic                accept;
  logic                tmr_load;
  logic                tmr_done;

`ifdef SDRAM_CTRL_WDOG_EN
  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic                err_q, err_d;
`endif

  assign cmd_ready       = (state_q == ST_IDLE);
  assign accept          = cmd_valid && cmd_ready;
  assign busy            = (state_q != ST_IDLE);
  assign state           = state_q;
  assign cmd_pagewrite   = (state_q == ST_LOAD);
  assign cmd_pageread    = (state_q == ST_READ);
  assign fifo_rst        = fifo_rst_q;
  assign sdramctrl_reset = sdrst_q;
  assign pages_cnt       = pages_q;

  assign tmr_load = accept && ((command == CMD_RESET_SDRAM) ||
                               ((command == CMD_RESET_FIFO) && (fifo_mask != '0)));

  sdram_rst_timer #(.CNT_W(CNT_W)) u_rst_timer (
    .clk_i      (sdramclk),
    .rst_n_i    (sdram_rst_n),
    .load_i     (tmr_load),
    .load_val_i ((command == CMD_RESET_SDRAM) ? SDRAM_LOAD : FIFO_LOAD),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    pages_d    = pages_q;
    target_d   = target_q;
    fifo_rst_d = fifo_rst_q;
    sdrst_d    = sdrst_q;
`ifdef SDRAM_CTRL_WDOG_EN
    wdog_d     = wdog_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef SDRAM_CTRL_WDOG_EN
          err_d  = 1'b0;
          wdog_d = '0;
`endif
          case (command)
            CMD_RUN: begin
              state_d  = ST_READ;
              pages_d  = '0;
              target_d = burst_pages;
            end
            CMD_LOAD: begin
              state_d  = ST_LOAD;
              pages_d  = '0;
              target_d = burst_pages;
            end
            CMD_RESET_FIFO: begin
              // An empty mask is accepted but has nothing to reset.
              if (fifo_mask != '0) begin
                state_d    = ST_RESET_FIFO;
                fifo_rst_d = fifo_mask;
              end
            end
            CMD_RESET_SDRAM: begin
              state_d = ST_RESET_SDRAM;
              sdrst_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RESET_SDRAM: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          sdrst_d = 1'b0;
        end
      end
      ST_RESET_FIFO: begin
        if (tmr_done) begin
          state_d    = ST_IDLE;
          fifo_rst_d = '0;
        end
      end
      ST_LOAD, ST_READ: begin
        if (page_done && (pages_q != '1)) pages_d = pages_q + 1'b1;
`ifdef SDRAM_CTRL_WDOG_EN
        if (page_done) wdog_d = '0;
        else           wdog_d = wdog_q + 1'b1;
`endif
        if (cmd_valid && (command == CMD_RETURN)) begin
          state_d = ST_IDLE;
        end else if ((target_q != '0) && (pages_d == target_q)) begin
          state_d = ST_IDLE;
`ifdef SDRAM_CTRL_WDOG_EN
        end else if (!page_done && (wdog_d == CNT_W'(WDOG_CYC))) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdramclk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q    <= ST_IDLE;
      pages_q    <= '0;
      target_q   <= '0;
      fifo_rst_q <= '0;
      sdrst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pages_q    <= pages_d;
      target_q   <= target_d;
      fifo_rst_q <= fifo_rst_d;
      sdrst_q    <= sdrst_d;
    end
  end

`ifdef SDRAM_CTRL_WDOG_EN
  always_ff @(posedge sdramclk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
